// File: rtl/branch_pkg.sv
// Shared types and defaults for the branch controller.
// Condition decode lives here so the top and any future users agree on encoding.
package branch_pkg;

    localparam int unsigned D_DEF      = 12;
    localparam int unsigned CYCLES_DEF = 6;
    localparam int unsigned L_DEF      = 5;

    typedef enum logic [1:0] {IDLE, PEND, ARMED} br_state_t;

    typedef enum logic [1:0] {C_ALWAYS, C_ZERO, C_NZERO, C_NEG} br_cond_t;

    function automatic logic cond_taken(input br_cond_t c, input logic z, input logic n);
        logic t;
        unique case (c)
            C_ALWAYS: t = 1'b1;
            C_ZERO:   t = z;
            C_NZERO:  t = ~z;
            C_NEG:    t = n;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/branch_lut.sv
// Branch target table: 2**L entries of D bits, synchronous write, combinational read.
// A read on the same edge as a write to that entry returns the old contents.
module branch_lut #(
    parameter int unsigned D = 12,
    parameter int unsigned L = 5
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         we_i,
    input  logic [L-1:0] waddr_i,
    input  logic [D-1:0] wdata_i,
    input  logic [L-1:0] raddr_i,
    output logic [D-1:0] rdata_o
);

    localparam int unsigned Depth = 2 ** L;

    logic [D-1:0] mem_q [Depth];
    logic [D-1:0] mem_d [Depth];

    always_comb begin
        mem_d = mem_q;
        if (we_i) mem_d[waddr_i] = wdata_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) mem_q <= '{default: '0};
        else       mem_q <= mem_d;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/branch_ctrl.sv
// Branch controller: latches decode requests, resolves them against ALU flags on EVAL_PHASE
// and holds absjump_en across the PC update edge. Define BRANCH_REL_EN for PC-relative branches.
module branch_ctrl
    import branch_pkg::*;
#(
    parameter int unsigned D          = D_DEF,
    parameter int unsigned CYCLES     = CYCLES_DEF,
    parameter int unsigned EVAL_PHASE = 4,
    parameter int unsigned L          = L_DEF,
    parameter int unsigned OFF_W      = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      br_req,
    input  logic [1:0]                br_cond,
    input  logic [L-1:0]              br_idx,
    input  logic                      br_rel,
    input  logic [OFF_W-1:0]          br_off,
    input  logic [D-1:0]              prog_ctr,
    input  logic                      flag_z,
    input  logic                      flag_n,
    input  logic                      lut_we,
    input  logic [L-1:0]              lut_waddr,
    input  logic [D-1:0]              lut_wdata,
    output logic                      absjump_en,
    output logic [D-1:0]              target,
    output logic [$clog2(CYCLES)-1:0] phase,
    output logic                      busy,
    output logic                      drop_err,
    output logic [7:0]                taken_cnt
);

    localparam int unsigned PhW = $clog2(CYCLES);

    br_state_t      state_q, state_d;
    br_cond_t       cond_q, cond_d;
    logic [L-1:0]   idx_q, idx_d;
    logic [PhW-1:0] phase_q, phase_d;
    logic           absjump_en_q, absjump_en_d;
    logic [D-1:0]   target_q, target_d;
    logic           busy_q, busy_d;
    logic           drop_err_q, drop_err_d;
    logic [7:0]     taken_cnt_q, taken_cnt_d;
    logic [D-1:0]   lut_rdata;
    logic [D-1:0]   resolved_tgt;

    branch_lut #(
        .D (D),
        .L (L)
    ) u_lut (
        .clk_i   (clk),
        .rst_i   (reset),
        .we_i    (lut_we),
        .waddr_i (lut_waddr),
        .wdata_i (lut_wdata),
        .raddr_i (idx_q),
        .rdata_o (lut_rdata)
    );

`ifdef BRANCH_REL_EN
    logic             rel_q, rel_d;
    logic [OFF_W-1:0] off_q, off_d;

    // Sign extension plus wrap modulo 2**D falls out of the D-bit add.
    assign resolved_tgt = rel_q ? prog_ctr + D'($signed(off_q)) : lut_rdata;
`else
    logic unused_rel;

    assign unused_rel   = ^{br_rel, br_off, prog_ctr};
    assign resolved_tgt = lut_rdata;
`endif

    always_comb begin
        state_d      = state_q;
        cond_d       = cond_q;
        idx_d        = idx_q;
        absjump_en_d = absjump_en_q;
        target_d     = target_q;
        drop_err_d   = drop_err_q;
        taken_cnt_d  = taken_cnt_q;
`ifdef BRANCH_REL_EN
        rel_d        = rel_q;
        off_d        = off_q;
`endif
        phase_d = (phase_q == PhW'(CYCLES - 1)) ? '0 : phase_q + 1'b1;

        unique case (state_q)
            IDLE: begin
                if (br_req) begin
                    cond_d  = br_cond_t'(br_cond);
                    idx_d   = br_idx;
`ifdef BRANCH_REL_EN
                    rel_d   = br_rel;
                    off_d   = br_off;
`endif
                    state_d = PEND;
                end
            end
            PEND: begin
                if (phase_q == PhW'(EVAL_PHASE)) begin
                    if (cond_taken(cond_q, flag_z, flag_n)) begin
                        state_d      = ARMED;
                        absjump_en_d = 1'b1;
                        target_d     = resolved_tgt;
                        if (taken_cnt_q != 8'hFF) taken_cnt_d = taken_cnt_q + 8'd1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            ARMED: begin
                // Commit edge: phase 0 before the edge is the PC update edge.
                if (phase_q == '0) begin
                    state_d      = IDLE;
                    absjump_en_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (br_req && (state_q != IDLE)) drop_err_d = 1'b1;
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cond_q       <= C_ALWAYS;
            idx_q        <= '0;
            phase_q      <= '0;
            absjump_en_q <= 1'b0;
            target_q     <= '0;
            busy_q       <= 1'b0;
            drop_err_q   <= 1'b0;
            taken_cnt_q  <= '0;
`ifdef BRANCH_REL_EN
            rel_q        <= 1'b0;
            off_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cond_q       <= cond_d;
            idx_q        <= idx_d;
            phase_q      <= phase_d;
            absjump_en_q <= absjump_en_d;
            target_q     <= target_d;
            busy_q       <= busy_d;
            drop_err_q   <= drop_err_d;
            taken_cnt_q  <= taken_cnt_d;
`ifdef BRANCH_REL_EN
            rel_q        <= rel_d;
            off_q        <= off_d;
`endif
        end
    end

    assign absjump_en = absjump_en_q;
    assign target     = target_q;
    assign phase      = phase_q;
    assign busy       = busy_q;
    assign drop_err   = drop_err_q;
    assign taken_cnt  = taken_cnt_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Self-checking bench for branch_ctrl: vector table plus scoreboard queue, and hand sequences
// for drop errors, table write collision, reset while armed, saturation and BRANCH_REL_EN.
module tb_branch_ctrl;

    localparam int unsigned EVAL = 4;
    localparam int unsigned CYC  = 6;

    logic        clk = 1'b0;
    logic        reset;
    logic        br_req;
    logic [1:0]  br_cond;
    logic [4:0]  br_idx;
    logic        br_rel;
    logic [7:0]  br_off;
    logic [11:0] prog_ctr;
    logic        flag_z;
    logic        flag_n;
    logic        lut_we;
    logic [4:0]  lut_waddr;
    logic [11:0] lut_wdata;
    logic        absjump_en;
    logic [11:0] target;
    logic [2:0]  phase;
    logic        busy;
    logic        drop_err;
    logic [7:0]  taken_cnt;

    branch_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .br_req     (br_req),
        .br_cond    (br_cond),
        .br_idx     (br_idx),
        .br_rel     (br_rel),
        .br_off     (br_off),
        .prog_ctr   (prog_ctr),
        .flag_z     (flag_z),
        .flag_n     (flag_n),
        .lut_we     (lut_we),
        .lut_waddr  (lut_waddr),
        .lut_wdata  (lut_wdata),
        .absjump_en (absjump_en),
        .target     (target),
        .phase      (phase),
        .busy       (busy),
        .drop_err   (drop_err),
        .taken_cnt  (taken_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  cond;
        logic [4:0]  idx;
        logic        fz;
        logic        fn;
        int unsigned rph;
        logic        taken;
        logic [11:0] tgt;
    } vec_t;

    typedef struct {
        logic        taken;
        logic [11:0] tgt;
        logic [7:0]  cnt;
    } exp_t;

    exp_t        sb_q[$];
    vec_t        vecs[9];
    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned tb_phase = 0;
    int unsigned exp_cnt = 0;

    task automatic check(input string nm, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        tb_phase = (tb_phase == CYC - 1) ? 0 : tb_phase + 1;
    endtask

    task automatic wait_phase(input int unsigned p);
        while (tb_phase != p) step();
    endtask

    task automatic lut_write(input logic [4:0] a, input logic [11:0] d);
        lut_we    = 1'b1;
        lut_waddr = a;
        lut_wdata = d;
        step();
        lut_we = 1'b0;
    endtask

    task automatic issue_branch(input logic [1:0] cond, input logic [4:0] idx, input logic fz,
                                input logic fn, input int unsigned rph, input logic taken,
                                input logic [11:0] tgt, input string nm);
        exp_t e;
        wait_phase(rph);
        flag_z  = fz;
        flag_n  = fn;
        br_cond = cond;
        br_idx  = idx;
        br_req  = 1'b1;
        step();
        br_req = 1'b0;
        if (taken && exp_cnt < 255) exp_cnt++;
        e.taken = taken;
        e.tgt   = tgt;
        e.cnt   = 8'(exp_cnt);
        sb_q.push_back(e);
        check({nm, " busy after req"}, busy, 1);
    endtask

    task automatic finish_branch(input string nm);
        exp_t        e;
        logic        seen = 1'b0;
        int unsigned fph = 0;
        logic [11:0] ts = '0;
        int unsigned n = 0;
        while (busy && n < 24) begin
            if (absjump_en && !seen) begin
                seen = 1'b1;
                fph  = phase;
                ts   = target;
            end
            step();
            n++;
        end
        check({nm, " busy cleared"}, busy, 0);
        if (sb_q.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL %s: scoreboard empty, got output with nothing expected", nm);
        end else begin
            e = sb_q.pop_front();
            check({nm, " taken"}, seen, e.taken);
            if (e.taken) begin
                check({nm, " target"}, ts, e.tgt);
                check({nm, " jump phase"}, fph, EVAL + 1);
            end
            check({nm, " idle phase"}, phase, e.taken ? 1 : EVAL + 1);
            check({nm, " taken_cnt"}, taken_cnt, e.cnt);
        end
        check({nm, " jump low"}, absjump_en, 0);
    endtask

    initial begin
        reset = 1'b1; br_req = 1'b0; br_cond = 2'd0; br_idx = '0; br_rel = 1'b0; br_off = '0;
        prog_ctr = '0; flag_z = 1'b0; flag_n = 1'b0; lut_we = 1'b0; lut_waddr = '0;
        lut_wdata = '0;

        vecs[0] = '{cond: 2'd0, idx: 5'd3,  fz: 1'b0, fn: 1'b0, rph: 1, taken: 1'b1, tgt: 12'h0A5};
        vecs[1] = '{cond: 2'd1, idx: 5'd7,  fz: 1'b0, fn: 1'b0, rph: 1, taken: 1'b0, tgt: 12'h000};
        vecs[2] = '{cond: 2'd1, idx: 5'd7,  fz: 1'b1, fn: 1'b0, rph: 2, taken: 1'b1, tgt: 12'h3C1};
        vecs[3] = '{cond: 2'd2, idx: 5'd9,  fz: 1'b1, fn: 1'b0, rph: 3, taken: 1'b0, tgt: 12'h000};
        vecs[4] = '{cond: 2'd2, idx: 5'd9,  fz: 1'b0, fn: 1'b1, rph: 5, taken: 1'b1, tgt: 12'hFFF};
        vecs[5] = '{cond: 2'd3, idx: 5'd31, fz: 1'b1, fn: 1'b0, rph: 0, taken: 1'b0, tgt: 12'h000};
        vecs[6] = '{cond: 2'd3, idx: 5'd31, fz: 1'b1, fn: 1'b1, rph: 4, taken: 1'b1, tgt: 12'h800};
        vecs[7] = '{cond: 2'd0, idx: 5'd0,  fz: 1'b0, fn: 1'b0, rph: 1, taken: 1'b1, tgt: 12'h000};
        vecs[8] = '{cond: 2'd3, idx: 5'd3,  fz: 1'b0, fn: 1'b1, rph: 2, taken: 1'b1, tgt: 12'h0A5};

        step(); step(); step();
        tb_phase = 0;
        check("reset absjump_en", absjump_en, 0);
        check("reset target", target, 0);
        check("reset phase", phase, 0);
        check("reset busy", busy, 0);
        check("reset drop_err", drop_err, 0);
        check("reset taken_cnt", taken_cnt, 0);
        reset = 1'b0;
        step();
        check("phase counts", phase, tb_phase);

        lut_write(5'd3, 12'h0A5);
        lut_write(5'd7, 12'h3C1);
        lut_write(5'd9, 12'hFFF);
        lut_write(5'd31, 12'h800);

        foreach (vecs[i]) begin
            issue_branch(vecs[i].cond, vecs[i].idx, vecs[i].fz, vecs[i].fn, vecs[i].rph,
                         vecs[i].taken, vecs[i].tgt, $sformatf("vec%0d", i));
            finish_branch($sformatf("vec%0d", i));
        end
        check("phase tracks model", phase, tb_phase);
        check("no drop_err yet", drop_err, 0);

        // Second request while pending is dropped.
        issue_branch(2'd0, 5'd7, 1'b0, 1'b0, 2, 1'b1, 12'h3C1, "drop");
        br_idx = 5'd9;
        br_req = 1'b1;
        step();
        br_req = 1'b0;
        check("drop_err set", drop_err, 1);
        finish_branch("drop");
        step();
        check("dropped req stays idle", busy, 0);

        // Table write on the evaluation edge: old data used, new data stored.
        issue_branch(2'd0, 5'd3, 1'b0, 1'b0, 1, 1'b1, 12'h0A5, "lutcol");
        wait_phase(EVAL);
        lut_we = 1'b1; lut_waddr = 5'd3; lut_wdata = 12'h123;
        step();
        lut_we = 1'b0;
        finish_branch("lutcol");
        issue_branch(2'd0, 5'd3, 1'b0, 1'b0, 3, 1'b1, 12'h123, "lutnew");
        finish_branch("lutnew");
        check("drop_err sticky", drop_err, 1);

        // Reset while armed.
        issue_branch(2'd0, 5'd9, 1'b0, 1'b0, 1, 1'b1, 12'hFFF, "rstarm");
        wait_phase(EVAL + 1);
        check("armed before reset", absjump_en, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        tb_phase = 0;
        void'(sb_q.pop_front());
        exp_cnt = 0;
        check("rst absjump_en", absjump_en, 0);
        check("rst phase", phase, 0);
        check("rst busy", busy, 0);
        check("rst drop_err", drop_err, 0);
        check("rst taken_cnt", taken_cnt, 0);
        issue_branch(2'd0, 5'd3, 1'b0, 1'b0, 2, 1'b1, 12'h000, "lut3 cleared");
        finish_branch("lut3 cleared");
        issue_branch(2'd0, 5'd31, 1'b0, 1'b0, 0, 1'b1, 12'h000, "lut31 cleared");
        finish_branch("lut31 cleared");

`ifdef BRANCH_REL_EN
        br_rel = 1'b1; prog_ctr = 12'h010; br_off = 8'hFD;
        issue_branch(2'd0, 5'd3, 1'b0, 1'b0, 1, 1'b1, 12'h00D, "rel neg");
        finish_branch("rel neg");
        prog_ctr = 12'hFFE; br_off = 8'h04;
        issue_branch(2'd0, 5'd3, 1'b0, 1'b0, 1, 1'b1, 12'h002, "rel wrap");
        finish_branch("rel wrap");
        br_rel = 1'b0;
`else
        lut_write(5'd3, 12'h456);
        br_rel = 1'b1; prog_ctr = 12'h010; br_off = 8'hFD;
        issue_branch(2'd0, 5'd3, 1'b0, 1'b0, 1, 1'b1, 12'h456, "rel ignored");
        finish_branch("rel ignored");
        br_rel = 1'b0;
`endif

        // Drive enough taken branches to saturate the counter.
        for (int k = 0; k < 256; k++) begin
            issue_branch(2'd0, 5'd0, 1'b0, 1'b0, tb_phase, 1'b1, 12'h000, "sat");
            finish_branch("sat");
        end
        check("taken_cnt saturated", taken_cnt, 255);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
